pdm_audio_tx: RTL



---
 rtl/pdm_tx_pkg.sv | 16 +
 rtl/pdm_audio_tx_if.sv | 20 ++
 rtl/pdm_sample_fifo.sv | 57 +++++
 rtl/pdm_audio_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pdm_tx_pkg.sv
// Shared constants and types for the PDM transmit path; the mic-side decimator imports the same
// constants so both ends agree on bit period and oversampling ratio.
package pdm_tx_pkg;

  typedef enum logic {IDLE, PLAY} pdm_tx_state_t;

  localparam int unsigned PDM_COUNT_PERIOD_DFLT = 32;
  localparam int unsigned OVERSAMPLE_DFLT       = 256;
  localparam logic [7:0]  U_MIDSCALE            = 8'd128;

  // Signed two's-complement sample to offset-binary density (0..255).
  function automatic logic [7:0] sample_to_u(input logic [7:0] s);
    return {~s[7], s[6:0]};
  endfunction

endpackage

// File: rtl/pdm_audio_tx_if.sv
// Sample handshake between the playback source (master) and the PDM transmitter (slave).
interface pdm_audio_tx_if;

  logic [7:0] sample_in;
  logic       sample_valid_in;
  logic       sample_ready_out;

  modport master (
    output sample_in,
    output sample_valid_in,
    input  sample_ready_out
  );

  modport slave (
    input  sample_in,
    input  sample_valid_in,
    output sample_ready_out
  );

endinterface

// File: rtl/pdm_sample_fifo.sv
// Small synchronous sample FIFO with asynchronous reset and a synchronous flush that overrides
// push/pop. Depth must be a power of two and at least 2.
module pdm_sample_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pdm_audio_tx.sv
// First-order error-feedback PDM transmitter: FIFO-fed 8-bit samples, each held for OVERSAMPLE
// bit strobes. Define PDM_TX_STATS_EN to add the saturating underrun_count_out port.
module pdm_audio_tx
  import pdm_tx_pkg::*;
#(
  parameter int unsigned PDM_COUNT_PERIOD = PDM_COUNT_PERIOD_DFLT,
  parameter int unsigned OVERSAMPLE       = OVERSAMPLE_DFLT,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 enable_in,
  pdm_audio_tx_if.slave        sample_if,
  output logic                 pdm_clk_out,
  output logic                 pdm_out,
  output logic                 playing_out,
`ifdef PDM_TX_STATS_EN
  output logic [15:0]          underrun_count_out,
`endif
  output logic                 underrun_out
);

  localparam int unsigned CW = $clog2(PDM_COUNT_PERIOD);
  localparam int unsigned HW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CTR_LAST  = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0] CTR_HALF  = CW'(PDM_COUNT_PERIOD / 2);
  localparam logic [HW-1:0] HCNT_LAST = HW'(OVERSAMPLE - 1);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);

  logic [CW-1:0] r_ctr;
  logic          r_pdm_clk;
  logic          r_pdm;
  logic [7:0]    r_acc;
  logic [7:0]    r_u;
  logic [HW-1:0] r_hcnt;
  pdm_tx_state_t r_state;
  logic          r_underrun;
  logic          r_enable;

  pdm_tx_state_t w_state_d;
  logic [7:0]    w_u_d;
  logic [7:0]    w_u_eff;
  logic [HW-1:0] w_hcnt_d;
  logic          w_underrun;
  logic          w_strobe;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [8:0]    w_sum;

  assign w_strobe = (r_ctr == CTR_HALF);
  assign w_push   = sample_if.sample_valid_in && sample_if.sample_ready_out && enable_in;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_u_eff};

  assign sample_if.sample_ready_out = !w_full;
  assign pdm_clk_out  = r_pdm_clk;
  assign pdm_out      = r_pdm;
  assign playing_out  = (r_state == PLAY);
  assign underrun_out = r_underrun;

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_flush (!enable_in),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (sample_if.sample_in),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bit timer never stops, even while disabled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ctr     <= '0;
      r_pdm_clk <= 1'b0;
    end else begin
      r_ctr     <= (r_ctr == CTR_LAST) ? '0 : r_ctr + 1'b1;
      r_pdm_clk <= (r_ctr < CTR_HALF);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_u_d      = r_u;
    w_u_eff    = r_u;
    w_hcnt_d   = r_hcnt;
    w_pop      = 1'b0;
    w_underrun = 1'b0;
    if (!enable_in) begin
      w_state_d = IDLE;
      w_u_d     = U_MIDSCALE;
      w_hcnt_d  = '0;
    end else if (w_strobe) begin
      unique case (r_state)
        IDLE: begin
          // The first sample drives this very strobe, which counts as its step 0.
          if (!w_empty) begin
            w_state_d = PLAY;
            w_pop     = 1'b1;
            w_u_eff   = sample_to_u(w_head);
            w_u_d     = w_u_eff;
            w_hcnt_d  = HCNT_ONE;
          end
        end
        PLAY: begin
          if (r_hcnt == HCNT_LAST) begin
            w_hcnt_d = '0;
            if (!w_empty) begin
              w_pop = 1'b1;
              w_u_d = sample_to_u(w_head);
            end else begin
              w_u_d      = U_MIDSCALE;
              w_underrun = 1'b1;
            end
          end else begin
            w_hcnt_d = r_hcnt + 1'b1;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_u        <= U_MIDSCALE;
      r_hcnt     <= '0;
      r_underrun <= 1'b0;
      r_enable   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_u        <= w_u_d;
      r_hcnt     <= w_hcnt_d;
      r_underrun <= w_underrun;
      r_enable   <= enable_in;
    end
  end

  // Accumulator clears once on the disabling edge so idle 50% keeps toggling afterwards.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_acc <= '0;
      r_pdm <= 1'b0;
    end else if (!enable_in && r_enable) begin
      r_acc <= '0;
    end else if (w_strobe) begin
      {r_pdm, r_acc} <= w_sum;
    end
  end

`ifdef PDM_TX_STATS_EN
  logic [15:0] r_urun_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_urun_cnt <= '0;
    end else if (!enable_in) begin
      r_urun_cnt <= '0;
    end else if (w_underrun && (r_urun_cnt != 16'hFFFF)) begin
      r_urun_cnt <= r_urun_cnt + 16'd1;
    end
  end

  assign underrun_count_out = r_urun_cnt;
`endif

endmodule
